// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module   : serial_adder
// Brief    : Bit-serial N-bit adder, LSB-first, start/busy/done handshake.
//            Optional subtract mode enabled by macro SERIAL_ADDER_SUB_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub_i,
`endif
    output logic [N-1:0] sum_o,
    output logic         cout_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [N-1:0]     a_sr_q;
    logic [N-1:0]     b_sr_q;
    logic [N-1:0]     sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    logic             s_d;
    logic             carry_d;
    logic [N-1:0]     res_d;
    logic             w_accept;
    logic             w_sub_load;
    logic             w_sub_run;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (w_accept) begin
            sub_q <= sub_i;
        end
    end

    assign w_sub_load = sub_i;
    assign w_sub_run  = sub_q;
`else
    assign w_sub_load = 1'b0;
    assign w_sub_run  = 1'b0;
`endif

    assign w_accept = start_i && (state_q != SHIFT);
    assign s_d      = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign carry_d  = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

    // Partial result keeps only the N-1 bits already produced; the new bit enters at the MSB.
    generate
        if (N == 1) begin : g_res_single
            assign res_d = s_d;
        end else begin : g_res_multi
            logic [N-2:0] res_q;

            assign res_d = {s_d, res_q};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_q <= '0;
                end else if (state_q == SHIFT) begin
                    res_q <= res_d[N-1:1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (w_accept) begin
                        // Subtract is a + ~b + ~cin; the final carry is inverted into a borrow.
                        a_sr_q  <= a_i;
                        b_sr_q  <= w_sub_load ? ~b_i : b_i;
                        carry_q <= cin_i ^ w_sub_load;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        sum_q   <= res_d;
                        cout_q  <= carry_d ^ w_sub_run;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_adder
// Brief    : Self-checking bench for serial_adder (N=8), directed and random ops.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         cin_i;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub_i;
`endif
    logic [N-1:0] sum_o;
    logic         cout_o;
    logic         busy_o;
    logic         done_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub_i),
`endif
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    // Reference: {cout, sum} = a + b + cin, or (a - b - cin) mod 2^N with borrow-out.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic cin, input logic sub);
        int d;
        logic [N-1:0] r;
        if (sub) begin
            d = int'(a) - int'(b) - int'(cin);
            r = d[N-1:0];
            return {(int'(a) < int'(b) + int'(cin)), r};
        end
        d = int'(a) + int'(b) + int'(cin);
        return d[N:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_sum"},  32'(sum_o),  32'h0);
        check({tag, "_cout"}, 32'(cout_o), 32'h0);
        check({tag, "_busy"}, 32'(busy_o), 32'h0);
        check({tag, "_done"}, 32'(done_o), 32'h0);
    endtask

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic sub);
        a_i     = a;
        b_i     = b;
        cin_i   = cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i   = sub;
`else
        if (sub) $display("note: subtract requested in add-only build");
`endif
        start_i = 1'b1;
    endtask

    // Called right after launch (at a falling edge); returns at the falling edge of the done cycle.
    task automatic wait_result(input logic [N-1:0] exp_sum, input logic exp_cout, input bit disturb);
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 1; i <= N; i++) begin
            check("busy_high", 32'(busy_o), 32'h1);
            check("done_low",  32'(done_o), 32'h0);
            if (disturb && i == 2) begin
                start_i = 1'b1;
                a_i     = N'($urandom);
                b_i     = N'($urandom);
                cin_i   = ~cin_i;
            end
            if (disturb && i == 3) start_i = 1'b0;
            @(negedge clk);
        end
        check("done_pulse", 32'(done_o), 32'h1);
        check("busy_done",  32'(busy_o), 32'h0);
        check("sum",        32'(sum_o),  32'(exp_sum));
        check("cout",       32'(cout_o), 32'(exp_cout));
    endtask

    task automatic check_hold(input logic [N-1:0] exp_sum, input logic exp_cout);
        @(negedge clk);
        check("hold_done", 32'(done_o), 32'h0);
        check("hold_busy", 32'(busy_o), 32'h0);
        check("hold_sum",  32'(sum_o),  32'(exp_sum));
        check("hold_cout", 32'(cout_o), 32'(exp_cout));
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic         rc, rs;
        logic [N:0]   e;
        bit           b2b;

        rst = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_idle_zero("rst");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle_zero("idle");
        end

        // Directed adds, then a back-to-back start in the DONE cycle
        launch(8'h3C, 8'h05, 1'b0, 1'b0);
        wait_result(8'h41, 1'b0, 0);
        check_hold(8'h41, 1'b0);
        check_hold(8'h41, 1'b0);
        @(negedge clk);
        launch(8'hFF, 8'h01, 1'b1, 1'b0);
        wait_result(8'h01, 1'b1, 0);
        launch(8'h10, 8'h20, 1'b0, 1'b0);
        wait_result(8'h30, 1'b0, 0);
        check_hold(8'h30, 1'b0);

        // Start re-pulsed and operands changed mid-flight: one done, original result
        @(negedge clk);
        launch(8'h7A, 8'h9C, 1'b1, 1'b0);
        wait_result(8'h17, 1'b1, 1);
        check_hold(8'h17, 1'b1);
        check_hold(8'h17, 1'b1);

        // Asynchronous reset during the fourth SHIFT cycle
        @(negedge clk);
        launch(8'h55, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_idle_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            check_idle_zero("post_rst");
        end
        launch(8'h55, 8'h22, 1'b0, 1'b0);
        wait_result(8'h77, 1'b0, 0);
        check_hold(8'h77, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        @(negedge clk);
        launch(8'h05, 8'h03, 1'b0, 1'b1);
        wait_result(8'h02, 1'b0, 0);
        launch(8'h03, 8'h05, 1'b0, 1'b1);
        wait_result(8'hFE, 1'b1, 0);
        launch(8'h00, 8'h00, 1'b1, 1'b1);
        wait_result(8'hFF, 1'b1, 0);
        launch(8'h10, 8'h20, 1'b0, 1'b0);
        wait_result(8'h30, 1'b0, 0);
        check_hold(8'h30, 1'b0);
`endif

        // Random operations against the reference model, some back-to-back
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            e   = model(ra, rb, rc, rs);
            b2b = ($urandom_range(0, 1) == 1);
            launch(ra, rb, rc, rs);
            wait_result(e[N-1:0], e[N], 0);
            if (!b2b) begin
                check_hold(e[N-1:0], e[N]);
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder with a start/busy/done handshake.
- Adds two latched operands LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Arithmetic counterpart to the team's subtractor blocks; used where area matters more than latency.
- Optional compile-time subtract mode reuses the same datapath in the opposite direction (difference/borrow).

Parameters:
- N, 8, operand and result width in bits; N >= 1.

Ports:
- clk    input   1   rising-edge clock
- rst    input   1   asynchronous, active-high reset
- start  input   1   request a new operation; sampled only in IDLE or DONE
- a      input   N   operand A, latched on accepted start
- b      input   N   operand B, latched on accepted start
- cin    input   1   carry-in (borrow-in in subtract mode), latched on accepted start
- sum    output  N   result (sum, or difference in subtract mode); valid when done=1, held until next accepted start
- cout   output  1   carry-out (borrow-out in subtract mode); same validity as sum
- busy   output  1   1 while in SHIFT
- done   output  1   one-cycle pulse when result becomes valid
- sub    input   1   present only with SERIAL_ADDER_SUB_EN; 1 selects subtract; latched on accepted start

Behaviour:
- Clocking/reset: one clock (clk). rst is asynchronous and active-high.
- Reset values: sum=0, cout=0, busy=0, done=0, state=IDLE; internal shift registers, carry flop and counter cleared.
- Counter: width $clog2(N+1).
- IDLE:
  - start=1 -> latch a, b and carry=cin into internal registers; bit counter=0; go to SHIFT.
  - start=0 -> stay in IDLE.
- SHIFT (busy=1), each cycle:
  - s = a_sr[0] ^ b_sr[0] ^ carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - a_sr and b_sr shift right by one.
  - s enters the result shift register at its MSB (result shifts right).
  - Counter increments.
  - When counter reaches N-1 in this cycle, go to DONE next edge.
- DONE (done=1 for exactly one cycle; busy=0):
  - sum = result register; cout = final carry.
  - start=1 -> accepted exactly as in IDLE; go to SHIFT.
  - start=0 -> go to IDLE.
  - sum/cout hold their values in IDLE.
- Latency: start sampled at edge T -> busy from T+1 to T+N; done=1 in cycle T+N+1.
- Throughput: one operation per N+1 cycles (back-to-back start in DONE).
- Width rule: unsigned arithmetic; {cout, sum} = a + b + cin, exactly N+1 bits, no overflow flag.
- Boundary conditions:
  - start while busy: ignored, no queueing.
  - Changes on a/b/cin after acceptance: no effect on the operation in flight.
  - N=1: one SHIFT cycle.
  - Reset mid-operation: immediate return to IDLE with all outputs cleared; the partial result is discarded.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - sub port exists and is latched with the operands.
  - sub=1: B register loaded with ~b; carry flop loaded with ~cin.
  - Result: sum = (a - b - cin) mod 2^N; cout = ~final_carry = borrow-out (1 when a < b + cin).
  - sub=0: identical to plain add.
- Not defined:
  - No sub port; add only.
  - Logic identical to the sub=0 path.

Test Plan (N=8):
- Reset then idle, start=0 for 5 cycles -> sum=0, cout=0, busy=0, done=0 throughout.
- a=8'h3C, b=8'h05, cin=0, start pulse at T -> busy cycles T+1..T+8; done pulse at T+9; sum=8'h41, cout=0; values held after done drops.
- a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1. Back-to-back start in the DONE cycle with a=8'h10, b=8'h20, cin=0 -> next done 9 cycles later with sum=8'h30, cout=0.
- Start accepted, then start re-pulsed and a/b changed during SHIFT -> original result unaffected; exactly one done pulse.
- Assert rst at cycle 4 of SHIFT -> all outputs 0 immediately (asynchronous); no done. A fresh start after reset computes correctly.
- With SERIAL_ADDER_SUB_EN:
  - a=8'h05, b=8'h03, cin=0, sub=1 -> sum=8'h02, cout=0.
  - a=8'h03, b=8'h05, cin=0, sub=1 -> sum=8'hFE, cout=1 (borrow).
  - a=8'h00, b=8'h00, cin=1, sub=1 -> sum=8'hFF, cout=1.
